avalon_bus_arbiter: RTL and testbench



---
 rtl/avalon_bus_arbiter.sv | 113 +++++++++++
 tb/tb_avalon_bus_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_bus_arbiter.sv
// Two-client arbiter for a single Avalon-MM master port (client 0 = ifetch, client 1 = load/store).
// Commands are registered onto the bus; read data is captured and returned with a one-cycle ack.
//
// state | meaning
// IDLE  | no transaction; sample requests and pick a winner
// BUS   | registered command on the bus, waiting for waitrequest=0
// RESP  | pulse the owner's ack, requests ignored
module avalon_bus_arbiter #(
    parameter int FIXED_PRIORITY = 0,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                c0_req,
    input  logic                c0_we,
    input  logic [ADDR_W-1:0]   c0_addr,
    input  logic [DATA_W-1:0]   c0_wdata,
    input  logic [DATA_W/8-1:0] c0_be,
    output logic                c0_ack,
    output logic [DATA_W-1:0]   c0_rdata,
    input  logic                c1_req,
    input  logic                c1_we,
    input  logic [ADDR_W-1:0]   c1_addr,
    input  logic [DATA_W-1:0]   c1_wdata,
    input  logic [DATA_W/8-1:0] c1_be,
    output logic                c1_ack,
    output logic [DATA_W-1:0]   c1_rdata,
    output logic [ADDR_W-1:0]   address,
    output logic                read,
    output logic                write,
    output logic [DATA_W-1:0]   writedata,
    output logic [DATA_W/8-1:0] byteenable,
    input  logic                waitrequest,
    input  logic [DATA_W-1:0]   readdata,
    output logic                busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUS  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]          state;
    logic                owner;
    logic                last_grant;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DATA_W/8-1:0] be_q;
    logic                grant_c1;

    // Round-robin hands contention to the client that did not win last time.
    always_comb begin
        grant_c1 = 1'b0;
        if (FIXED_PRIORITY != 0)
            grant_c1 = ~c0_req;
        else if (c0_req && c1_req)
            grant_c1 = ~last_grant;
        else
            grant_c1 = c1_req;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            c0_rdata   <= '0;
            c1_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (c0_req || c1_req) begin
                        owner      <= grant_c1;
                        last_grant <= grant_c1;
                        we_q       <= grant_c1 ? c1_we    : c0_we;
                        addr_q     <= grant_c1 ? c1_addr  : c0_addr;
                        wdata_q    <= grant_c1 ? c1_wdata : c0_wdata;
                        be_q       <= grant_c1 ? c1_be    : c0_be;
                        state      <= BUS;
                    end
                end
                BUS: begin
                    if (!waitrequest) begin
                        if (!we_q) begin
                            if (owner)
                                c1_rdata <= readdata;
                            else
                                c0_rdata <= readdata;
                        end
                        state <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign address    = addr_q;
    assign writedata  = wdata_q;
    assign byteenable = be_q;
    assign read       = (state == BUS) && !we_q;
    assign write      = (state == BUS) && we_q;
    assign c0_ack     = (state == RESP) && !owner;
    assign c1_ack     = (state == RESP) && owner;
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Bench for avalon_bus_arbiter: a round-robin and a fixed-priority instance share the stimulus;
// expected acks/read data are queued at stimulus time and checked when an ack appears.
module tb_avalon_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        c0_req = 1'b0, c0_we = 1'b0, c1_req = 1'b0, c1_we = 1'b0;
    logic [31:0] c0_addr = '0, c0_wdata = '0, c1_addr = '0, c1_wdata = '0;
    logic [3:0]  c0_be = '0, c1_be = '0;
    logic        waitrequest = 1'b0;
    logic [31:0] rd_val = '0;
    logic        rd_mode = 1'b0;
    logic [31:0] readdata;

    logic        c0_ack, c1_ack, read, write, busy;
    logic [31:0] c0_rdata, c1_rdata, address, writedata;
    logic [3:0]  byteenable;

    logic        f_c0_ack, f_c1_ack, f_read, f_write, f_busy;
    logic [31:0] f_c0_rdata, f_c1_rdata, f_address, f_writedata;
    logic [3:0]  f_byteenable;

    localparam logic [31:0] RD_KEY = 32'h5A5A5A5A;

    assign readdata = rd_mode ? (address ^ RD_KEY) : rd_val;

    always #5 clk = ~clk;

    avalon_bus_arbiter #(.FIXED_PRIORITY(0), .ADDR_W(32), .DATA_W(32)) u_rr (
        .clk(clk), .reset(reset),
        .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata), .c0_be(c0_be),
        .c0_ack(c0_ack), .c0_rdata(c0_rdata),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata), .c1_be(c1_be),
        .c1_ack(c1_ack), .c1_rdata(c1_rdata),
        .address(address), .read(read), .write(write), .writedata(writedata),
        .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata), .busy(busy)
    );

    avalon_bus_arbiter #(.FIXED_PRIORITY(1), .ADDR_W(32), .DATA_W(32)) u_fp (
        .clk(clk), .reset(reset),
        .c0_req(c0_req), .c0_we(c0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata), .c0_be(c0_be),
        .c0_ack(f_c0_ack), .c0_rdata(f_c0_rdata),
        .c1_req(c1_req), .c1_we(c1_we), .c1_addr(c1_addr), .c1_wdata(c1_wdata), .c1_be(c1_be),
        .c1_ack(f_c1_ack), .c1_rdata(f_c1_rdata),
        .address(f_address), .read(f_read), .write(f_write), .writedata(f_writedata),
        .byteenable(f_byteenable), .waitrequest(waitrequest), .readdata(readdata), .busy(f_busy)
    );

    typedef struct {
        int          client;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_rd [2];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every ack pops the next expected grant.
    always @(negedge clk) begin
        if (!reset && (c0_ack || c1_ack)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", {c1_ack, c0_ack}, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ack_both", c0_ack & c1_ack, 0);
                check("ack_client", c1_ack ? 1 : 0, e.client);
                check("ack_rdata", e.client == 1 ? c1_rdata : c0_rdata, e.rdata);
                check("other_rdata", e.client == 1 ? c0_rdata : c1_rdata, model_rd[1 - e.client]);
                model_rd[e.client] = e.rdata;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rw", {read, write}, 0);
        check("rst_busy", busy, 0);
        check("rst_ack", {c0_ack, c1_ack}, 0);
        check("rst_rdata0", c0_rdata, 0);
        check("rst_rdata1", c1_rdata, 0);
        check("rst_addr", address, 0);
        @(negedge clk);
        reset = 1'b0;
        model_rd[0] = '0;
        model_rd[1] = '0;
    endtask

    task automatic do_txn(input int cl, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          input logic [31:0] rdv, input int nwait);
        exp_t e;
        @(negedge clk);
        if (cl == 0) begin
            c0_req = 1'b1; c0_we = we; c0_addr = addr; c0_wdata = wdata; c0_be = be;
        end else begin
            c1_req = 1'b1; c1_we = we; c1_addr = addr; c1_wdata = wdata; c1_be = be;
        end
        waitrequest = (nwait > 0);
        rd_mode     = 1'b0;
        rd_val      = 32'hBAD0BAD0;
        e.client = cl;
        e.rdata  = we ? model_rd[cl] : rdv;
        exp_q.push_back(e);
        for (int i = 0; i <= nwait; i++) begin
            @(posedge clk);
            #1;
            check("bus_read", read, !we);
            check("bus_write", write, we);
            check("bus_addr", address, addr);
            check("bus_busy", busy, 1);
            check("bus_early_ack", {c0_ack, c1_ack}, 0);
            if (we) begin
                check("bus_wdata", writedata, wdata);
                check("bus_be", byteenable, be);
            end
            waitrequest = (i < nwait);
            rd_val      = (i < nwait) ? 32'hBAD0BAD0 : rdv;
        end
        @(posedge clk);
        #1;
        check("resp_rw", {read, write}, 0);
        check("ack_owner", cl == 1 ? c1_ack : c0_ack, 1);
        check("ack_other", cl == 1 ? c0_ack : c1_ack, 0);
        check("fp_ack_owner", cl == 1 ? f_c1_ack : f_c0_ack, 1);
        c0_req = 1'b0;
        c1_req = 1'b0;
        waitrequest = 1'b0;
        @(posedge clk);
        #1;
        check("idle_busy", busy, 0);
        check("ack_one_cycle", {c0_ack, c1_ack}, 0);
    endtask

    // Both clients request continuously; zero wait, read data derived from the address.
    task automatic contend(input int ngrants);
        exp_t e;
        @(negedge clk);
        c0_req = 1'b1; c0_we = 1'b0; c0_addr = 32'h0000_0100;
        c1_req = 1'b1; c1_we = 1'b0; c1_addr = 32'h0000_0200;
        waitrequest = 1'b0;
        rd_mode     = 1'b1;
        for (int g = 0; g < ngrants; g++) begin
            e.client = g % 2;
            e.rdata  = (g % 2 == 1 ? 32'h0000_0200 : 32'h0000_0100) ^ RD_KEY;
            exp_q.push_back(e);
        end
        for (int k = 0; k < 3 * ngrants; k++) begin
            @(posedge clk);
            #1;
            check("rr_c0_ack", c0_ack, (k % 3 == 1) && ((k / 3) % 2 == 0));
            check("rr_c1_ack", c1_ack, (k % 3 == 1) && ((k / 3) % 2 == 1));
            check("rr_read", read, k % 3 == 0);
            check("fp_c0_ack", f_c0_ack, k % 3 == 1);
            check("fp_c1_ack", f_c1_ack, 0);
        end
        c0_req  = 1'b0;
        c1_req  = 1'b0;
        rd_mode = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_rd[0] = '0;
        model_rd[1] = '0;
        do_reset();

        do_txn(0, 1'b0, 32'hBFC0_0000, 32'h0, 4'hF, 32'h1234_5678, 0);
        do_txn(1, 1'b0, 32'h0000_1000, 32'h0, 4'hF, 32'hCAFE_F00D, 3);
        do_txn(1, 1'b1, 32'h0000_2004, 32'hDEAD_BEEF, 4'b0011, 32'h0, 0);
        do_txn(0, 1'b1, 32'h0000_3000, 32'h0102_0304, 4'b0000, 32'h0, 1);
        do_txn(0, 1'b0, 32'hBFC0_0004, 32'h0, 4'hF, 32'h8765_4321, 2);

        do_reset();
        contend(4);
        @(posedge clk);
        #1;
        check("contend_drain_busy", busy, 0);

        // Abort a waiting transaction with reset; no ack may follow.
        @(negedge clk);
        c1_req = 1'b1; c1_we = 1'b0; c1_addr = 32'h0000_4000;
        waitrequest = 1'b1;
        @(posedge clk);
        #1;
        check("abort_bus_read", read, 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_rw", {read, write}, 0);
        check("abort_busy", busy, 0);
        check("abort_ack", {c0_ack, c1_ack}, 0);
        check("abort_rdata1", c1_rdata, 0);
        @(negedge clk);
        c1_req = 1'b0;
        waitrequest = 1'b0;
        reset = 1'b0;
        model_rd[0] = '0;
        model_rd[1] = '0;
        @(posedge clk);
        #1;
        check("abort_no_ack", {c0_ack, c1_ack}, 0);
        contend(2);
        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
